// File: rtl/branch_ext.sv
// ARM B/BL offset extender and registered branch target.
// Offset path is combinational; target is captured on ld.
module branch_ext #(
  parameter logic [31:0] PC_AHEAD = 32'd8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [23:0] ofst,
  output logic [31:0] out,
  input  logic [31:0] pc,
  input  logic        ld,
  output logic [31:0] target,
  output logic        target_vld
);

  // word offset -> sign-extended byte offset
  assign out = {{6{ofst[23]}}, ofst, 2'b00};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      target     <= 32'h0;
      target_vld <= 1'b0;
    end else if (ld) begin
      target     <= pc + PC_AHEAD + out;
      target_vld <= 1'b1;
    end
  end

endmodule

// File: tb/tb_branch_ext.sv
// Scoreboard bench for branch_ext: queued expected targets,
// monitor compares on every clock; offset path checked directly.
module tb_branch_ext;

  logic        clk = 1'b0;
  logic        reset;
  logic [23:0] ofst;
  logic [31:0] out;
  logic [31:0] pc;
  logic        ld;
  logic [31:0] target;
  logic        target_vld;

  int errors = 0;
  int checks = 0;

  logic [31:0] expq[$];
  logic [31:0] exp_tgt = 32'h0;
  logic        exp_vld = 1'b0;

  branch_ext dut (
    .clk        (clk),
    .reset      (reset),
    .ofst       (ofst),
    .out        (out),
    .pc         (pc),
    .ld         (ld),
    .target     (target),
    .target_vld (target_vld)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ext_ref(logic [23:0] o);
    longint s;
    s = longint'($signed(o)) * 4;
    return s[31:0];
  endfunction

  function automatic logic [31:0] tgt_ref(logic [31:0] p, logic [23:0] o);
    longint s;
    s = longint'(p) + 8 + longint'($signed(o)) * 4;
    return s[31:0];
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %h want %h at %0t", name, act, want, $time);
    end
  endtask

  // drive one cycle at the falling edge; queue the expected capture
  task automatic step(logic l, logic [31:0] p, logic [23:0] o,
                      logic [31:0] want_out, logic [31:0] want_tgt);
    @(negedge clk);
    ld   = l;
    pc   = p;
    ofst = o;
    if (l && !reset) expq.push_back(want_tgt);
    #1;
    chk("out", out, want_out);
  endtask

  task automatic rstep(logic l, logic [31:0] p, logic [23:0] o);
    step(l, p, o, ext_ref(o), tgt_ref(p, o));
  endtask

  // monitor: sample controls at the edge, compare just after it
  always @(posedge clk) begin
    logic l, r;
    l = ld;
    r = reset;
    #1;
    if (r) begin
      exp_tgt = 32'h0;
      exp_vld = 1'b0;
    end else if (l) begin
      if (expq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL scoreboard_empty: capture with no expected entry at %0t",
                 $time);
      end else begin
        exp_tgt = expq.pop_front();
        exp_vld = 1'b1;
      end
    end
    chk("target", target, exp_tgt);
    chk("target_vld", {31'h0, target_vld}, {31'h0, exp_vld});
  end

  logic [23:0] bofst[4] = '{24'h000001, 24'h7FFFFF, 24'h800000, 24'hFFFFFF};
  logic [31:0] bout[4]  = '{32'h00000004, 32'h01FFFFFC,
                            32'hFE000000, 32'hFFFFFFFC};

  initial begin
    reset = 1'b1;
    ld    = 1'b0;
    pc    = 32'h0;
    ofst  = 24'h0;
    #1;
    chk("reset_target", target, 32'h0);
    chk("reset_vld", {31'h0, target_vld}, 32'h0);
    ofst = 24'hD55555;
    #4;
    chk("out_comb_d55555", out, 32'hFF555554);

    // release reset mid-cycle; first capture on next edge with ld
    @(posedge clk);
    #3 reset = 1'b0;
    step(1'b1, 32'h00001000, 24'hFFFFFE, 32'hFFFFFFF8, 32'h00001000);
    step(1'b0, 32'h00001000, 24'hFFFFFE, 32'hFFFFFFF8, 32'h0);
    step(1'b1, 32'hFFFFFFF8, 24'h000001, 32'h00000004, 32'h00000004);

    // hold while inputs wander
    for (int i = 0; i < 4; i++) begin
      logic [31:0] p;
      logic [23:0] o;
      p = $urandom;
      o = 24'($urandom);
      step(1'b0, p, o, ext_ref(o), 32'h0);
    end

    // async reset after a capture, no edge needed
    @(posedge clk);
    #3 reset = 1'b1;
    #1;
    chk("async_rst_target", target, 32'h0);
    chk("async_rst_vld", {31'h0, target_vld}, 32'h0);
    step(1'b1, 32'h12345678, 24'h000010, 32'h00000040, 32'h0);
    @(posedge clk);
    #3 reset = 1'b0;

    // reset arriving together with ld: reset wins
    step(1'b1, 32'h00000100, 24'h000002, 32'h00000008, 32'h00000110);
    @(negedge clk);
    reset = 1'b1;
    ld    = 1'b1;
    pc    = 32'h00002000;
    @(posedge clk);
    #3 reset = 1'b0;
    ld = 1'b0;

    for (int i = 0; i < 4; i++)
      step(1'b1, 32'h00004000, bofst[i], bout[i],
           tgt_ref(32'h00004000, bofst[i]));

    for (int i = 0; i < 300; i++) begin
      logic [31:0] p;
      logic [23:0] o;
      logic l;
      p = $urandom;
      o = 24'($urandom);
      if ($urandom_range(0, 7) == 0) o = bofst[$urandom_range(0, 3)];
      if ($urandom_range(0, 7) == 0) p = 32'hFFFFFFF0 | 32'($urandom_range(0, 15));
      l = ($urandom_range(0, 2) != 0);
      rstep(l, p, o);
    end

    @(negedge clk);
    ld = 1'b0;
    repeat (3) @(negedge clk);
    chk("queue_drained", 32'(expq.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
